axi_led_pwm_bank: RTL
=====================

AXI_LED_PWM_BANK -- requirements
Module: axi_led_pwm_bank

Interface
REQ-001 Parameter NUM_LEDS, default 16: number of LED outputs, legal range 1..32.
REQ-002 Parameter PWM_BITS, default 8: PWM duty and counter width, legal range 2..16.
REQ-003 Parameter AW, default 8: AXI address width in bits; must satisfy AW >= 2 + ceil(log2(4+NUM_LEDS)).
REQ-004 clk  in  1  sole clock; all logic is on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 leds  out  NUM_LEDS  registered LED drive; 1 = lit.
REQ-007 S_AXI_AWADDR in AW, S_AXI_AWVALID in 1, S_AXI_AWREADY out 1, S_AXI_AWPROT in 3 (ignored): AXI4-Lite write-address channel.
REQ-008 S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1: AXI4-Lite write-data channel.
REQ-009 S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1: AXI4-Lite write-response channel.
REQ-010 S_AXI_ARADDR in AW, S_AXI_ARVALID in 1, S_AXI_ARREADY out 1, S_AXI_ARPROT in 3 (ignored): AXI4-Lite read-address channel.
REQ-011 S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1: AXI4-Lite read-data channel.

Function
REQ-012 Register index = ADDR[AW-1:2]; ADDR[1:0] ignored.
REQ-013 Register map: 0 ENABLE[NUM_LEDS-1:0] RW; 1 BLINK[NUM_LEDS-1:0] RW; 2 BLINK_HALF[31:0] RW; 3 STATUS RO (bit0 = blink phase, bits 31:1 = 0); 4+i DUTY_i[PWM_BITS-1:0] RW for i = 0..NUM_LEDS-1.
REQ-014 Read-data bits above a register's width return 0; write-data bits above it are discarded.
REQ-015 Write FSM states: W_IDLE, W_RESP.
- W_IDLE: when AWVALID and WVALID are both 1, pulse AWREADY and WREADY together for exactly one cycle, perform the write, go to W_RESP.
- W_RESP: BVALID = 1; on BREADY = 1, return to W_IDLE.
- AWREADY and WREADY are never asserted singly.
REQ-016 Writes honour WSTRB per byte lane; WSTRB = 0 gives an OKAY response and changes nothing.
REQ-017 BRESP values: OKAY (0) for RW registers; SLVERR (2) for STATUS, with no state change; DECERR (3) for unmapped indices, with no state change.
REQ-018 Read FSM states: R_IDLE, R_DATA.
- R_IDLE: on ARVALID, pulse ARREADY for one cycle, latch RDATA/RRESP, go to R_DATA.
- R_DATA: RVALID = 1 with RDATA/RRESP held stable; on RREADY = 1, return to R_IDLE.
- Unmapped read: RDATA = 0, RRESP = DECERR.
REQ-019 Read and write FSMs are independent and may complete in the same cycle.
REQ-020 A read of a register written in the same cycle returns the pre-write value.
REQ-021 PWM counter: PWM_BITS wide, increments every clk, wraps from 2^PWM_BITS-1 to 0.
REQ-022 Each DUTY_i has a shadow copy; the shadow loads from DUTY_i only in the cycle the counter wraps to 0, so no partial PWM period occurs.
REQ-023 pwm_i rules:
- pwm_i = 1 when shadow_i = all-ones (fully on).
- Otherwise pwm_i = (counter < shadow_i).
- shadow_i = 0 therefore gives pwm_i = 0 (fully off).
REQ-024 Blink counter: 32-bit; counts 0..BLINK_HALF-1, then resets to 0 and toggles the blink phase.
- BLINK_HALF = 0: counter held at 0, phase forced to 1.
- A write to BLINK_HALF clears the blink counter; phase is unchanged.
REQ-025 leds[i] is registered from ENABLE[i] & pwm_i & (~BLINK[i] | phase), so LEDs have one clk of latency from their inputs.

Reset
REQ-026 On reset = 1 at a clock edge, the block is initialised as follows:
- ENABLE = 0, BLINK = 0, BLINK_HALF = 0.
- All DUTY_i and shadows = all-ones.
- PWM and blink counters = 0; phase = 1; leds = 0.
- FSMs go to idle; AWREADY, WREADY, BVALID, ARREADY, RVALID = 0; BRESP, RRESP, RDATA = 0.
REQ-027 Reset asserted mid-transaction abandons that transaction without a response; the master must re-issue it.

Verification
REQ-028 Release reset, read indices 0..4 -> 0, 0, 0, 1 (phase), 0xFF, all RRESP OKAY; leds = 0.
REQ-029 Write ENABLE = 0x0001 with DUTY_0 = 0x40 (PWM_BITS = 8) -> after the next counter wrap, leds[0] is high for exactly 64 of every 256 cycles.
REQ-030 Write ENABLE = 0x0003, BLINK = 0x0002, BLINK_HALF = 10 -> leds[1] toggles every 10 cycles, leds[0] stays high, STATUS bit0 tracks leds[1].
REQ-031 Write STATUS -> BRESP = SLVERR; write index 4+NUM_LEDS -> BRESP = DECERR; registers unchanged.
REQ-032 Write ENABLE = 0xFFFF with WSTRB = 0b0010 -> ENABLE = 0xFF00; hold BREADY low 5 cycles -> BVALID stays high and no new AW/W is accepted.
REQ-033 Assert reset during R_DATA with RREADY held low -> RVALID = 0 on the next cycle and all registers return to their reset values.

Source files
------------

// File: rtl/axi_led_pwm_bank.sv
// AXI4-Lite controlled LED bank: per-LED enable, PWM duty (glitch-free shadowed) and blink gating.
// state | meaning: W_IDLE wait AW+W / W_RESP hold BVALID; R_IDLE wait AR / R_DATA hold RVALID.
module axi_led_pwm_bank #(
  parameter int NUM_LEDS = 16,
  parameter int PWM_BITS = 8,
  parameter int AW       = 8
) (
  input  logic                clk,
  input  logic                reset,
  output logic [NUM_LEDS-1:0] leds,
  input  logic [AW-1:0]       S_AXI_AWADDR,
  input  logic                S_AXI_AWVALID,
  output logic                S_AXI_AWREADY,
  input  logic [2:0]          S_AXI_AWPROT,
  input  logic [31:0]         S_AXI_WDATA,
  input  logic [3:0]          S_AXI_WSTRB,
  input  logic                S_AXI_WVALID,
  output logic                S_AXI_WREADY,
  output logic [1:0]          S_AXI_BRESP,
  output logic                S_AXI_BVALID,
  input  logic                S_AXI_BREADY,
  input  logic [AW-1:0]       S_AXI_ARADDR,
  input  logic                S_AXI_ARVALID,
  output logic                S_AXI_ARREADY,
  input  logic [2:0]          S_AXI_ARPROT,
  output logic [31:0]         S_AXI_RDATA,
  output logic [1:0]          S_AXI_RRESP,
  output logic                S_AXI_RVALID,
  input  logic                S_AXI_RREADY
);

  localparam int IW = AW - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  logic [0:0]          wstate, rstate;
  logic                aw_w_ready;
  logic [NUM_LEDS-1:0] enable_r, blink_r, led_next;
  logic [31:0]         blink_half, blink_cnt;
  logic                phase;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty   [NUM_LEDS];
  logic [PWM_BITS-1:0] shadow [NUM_LEDS];

  logic [IW-1:0] widx, ridx;
  logic [31:0]   w_old, w_new, r_data;
  logic [1:0]    w_resp, r_resp;
  logic          wr_fire, wr_ok, blink_clr;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign widx = S_AXI_AWADDR[AW-1:2];
  assign ridx = S_AXI_ARADDR[AW-1:2];
  assign S_AXI_AWREADY = aw_w_ready;
  assign S_AXI_WREADY  = aw_w_ready;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] nw,
                                              input logic [3:0] strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[8*b +: 8] = strb[b] ? nw[8*b +: 8] : old[8*b +: 8];
    return res;
  endfunction

  always_comb begin
    w_old  = '0;
    w_resp = RESP_DECERR;
    if (widx == IW'(0)) begin
      w_old[NUM_LEDS-1:0] = enable_r;
      w_resp = RESP_OKAY;
    end else if (widx == IW'(1)) begin
      w_old[NUM_LEDS-1:0] = blink_r;
      w_resp = RESP_OKAY;
    end else if (widx == IW'(2)) begin
      w_old  = blink_half;
      w_resp = RESP_OKAY;
    end else if (widx == IW'(3)) begin
      w_resp = RESP_SLVERR;
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (widx == IW'(4 + i)) begin
          w_old[PWM_BITS-1:0] = duty[i];
          w_resp = RESP_OKAY;
        end
      end
    end
  end

  assign w_new     = merge_bytes(w_old, S_AXI_WDATA, S_AXI_WSTRB);
  assign wr_fire   = (wstate == W_IDLE) && aw_w_ready;
  assign wr_ok     = wr_fire && (w_resp == RESP_OKAY);
  assign blink_clr = wr_ok && (widx == IW'(2)) && (S_AXI_WSTRB != 4'b0000);

  always_comb begin
    r_data = '0;
    r_resp = RESP_DECERR;
    if (ridx == IW'(0)) begin
      r_data[NUM_LEDS-1:0] = enable_r;
      r_resp = RESP_OKAY;
    end else if (ridx == IW'(1)) begin
      r_data[NUM_LEDS-1:0] = blink_r;
      r_resp = RESP_OKAY;
    end else if (ridx == IW'(2)) begin
      r_data = blink_half;
      r_resp = RESP_OKAY;
    end else if (ridx == IW'(3)) begin
      r_data[0] = phase;
      r_resp = RESP_OKAY;
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (ridx == IW'(4 + i)) begin
          r_data[PWM_BITS-1:0] = duty[i];
          r_resp = RESP_OKAY;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wstate       <= W_IDLE;
      aw_w_ready   <= 1'b0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= 2'b00;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (aw_w_ready) begin
            aw_w_ready   <= 1'b0;
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP  <= w_resp;
            wstate       <= W_RESP;
          end else if (S_AXI_AWVALID && S_AXI_WVALID) begin
            aw_w_ready <= 1'b1;
          end
        end
        default: begin
          if (S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
            wstate       <= W_IDLE;
          end
        end
      endcase
    end
  end

  // Read data is captured from the pre-write register values, so a same-cycle write is not visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      rstate        <= R_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= 2'b00;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (S_AXI_ARREADY) begin
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b1;
            S_AXI_RDATA   <= r_data;
            S_AXI_RRESP   <= r_resp;
            rstate        <= R_DATA;
          end else if (S_AXI_ARVALID) begin
            S_AXI_ARREADY <= 1'b1;
          end
        end
        default: begin
          if (S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
            rstate       <= R_IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    led_next = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      led_next[i] = enable_r[i] & ((&shadow[i]) | (pwm_cnt < shadow[i])) & (~blink_r[i] | phase);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_r   <= '0;
      blink_r    <= '0;
      blink_half <= '0;
      blink_cnt  <= '0;
      phase      <= 1'b1;
      pwm_cnt    <= '0;
      leds       <= '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        duty[i]   <= '1;
        shadow[i] <= '1;
      end
    end else begin
      if (wr_ok) begin
        if (widx == IW'(0)) enable_r   <= w_new[NUM_LEDS-1:0];
        if (widx == IW'(1)) blink_r    <= w_new[NUM_LEDS-1:0];
        if (widx == IW'(2)) blink_half <= w_new;
        for (int i = 0; i < NUM_LEDS; i++) begin
          if (widx == IW'(4 + i)) duty[i] <= w_new[PWM_BITS-1:0];
        end
      end
      pwm_cnt <= pwm_cnt + 1'b1;
      // Shadows only follow DUTY at the wrap so every PWM period is complete.
      if (&pwm_cnt) begin
        for (int i = 0; i < NUM_LEDS; i++) shadow[i] <= duty[i];
      end
      if (blink_clr) begin
        blink_cnt <= '0;
      end else if (blink_half == 32'd0) begin
        blink_cnt <= '0;
        phase     <= 1'b1;
      end else if (blink_cnt >= blink_half - 32'd1) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 32'd1;
      end
      leds <= led_next;
    end
  end

endmodule
